// File: rtl/sram_b_burst_reader.sv
// sram_b_burst_reader: read-side burst master for operand SRAM B.
// Reads burst_len bytes from base_addr upward (address wraps mod 2**ADDR_W)
// and streams them on a valid/ready byte interface. A tag pipeline tracks
// reads in flight so that the output FIFO can never overflow.
// Optional feature macro: SRAM_B_RD_CHECKSUM_EN (16-bit running sum of the
// bytes handshaked in the current burst; tied to zero when undefined).
module sram_b_burst_reader #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 8,
    parameter int READ_LAT   = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              rpll_clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   burst_len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] sram_B_addr,
    output logic              sram_B_we,
    output logic [DATA_W-1:0] sram_B_din,
    input  logic [DATA_W-1:0] sram_B_dout,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic [15:0]       checksum
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int SUM_W = CNT_W + 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_reg;
    logic [ADDR_W:0]   len_reg;
    logic [ADDR_W:0]   issue_left_reg;
    logic [ADDR_W:0]   beat_reg;
    // tag_reg[0] marks a valid address on sram_B_addr; tag_reg[READ_LAT]
    // marks the cycle in which the matching sram_B_dout is valid.
    logic [READ_LAT:0] tag_reg;
    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  count_next;
    logic [SUM_W-1:0]  inflight;

    logic accept;
    logic issue;
    logic issue_now;
    logic push;
    logic pop;
    logic credit;
    logic drain_done;

    assign sram_B_we  = 1'b0;
    assign sram_B_din = '0;

    assign accept     = (state_reg == IDLE) && start;
    assign push       = tag_reg[READ_LAT];
    assign m_valid    = (count_reg != '0);
    assign pop        = m_valid && m_ready;
    assign count_next = count_reg + CNT_W'(push) - CNT_W'(pop);

    // Count every read that will still need a FIFO slot (all tag stages).
    always_comb begin
        inflight = '0;
        for (int i = 0; i <= READ_LAT; i++) begin
            inflight = inflight + SUM_W'(tag_reg[i]);
        end
    end

    // A slot freed by this cycle's pop may be reused, which keeps one byte
    // per cycle flowing under continuous ready even with READ_LAT=2.
    assign credit = (SUM_W'(count_reg) + inflight + SUM_W'(1))
                    <= (SUM_W'(FIFO_DEPTH) + SUM_W'(pop));

    assign issue      = (state_reg == ISSUE) && credit;
    assign issue_now  = (accept && (burst_len != '0)) || issue;
    assign drain_done = (state_reg == DRAIN) && (count_next == '0)
                        && (tag_reg[READ_LAT-1:0] == '0);

    assign m_data = m_valid ? fifo_mem[rd_ptr_reg] : '0;
    assign m_last = m_valid && (beat_reg == (len_reg - (ADDR_W+1)'(1)));

    // Burst control FSM: address issue, drain wait, one-cycle done pulse.
    always_ff @(posedge rpll_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            sram_B_addr    <= '0;
            len_reg        <= '0;
            issue_left_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        len_reg <= burst_len;
                        busy    <= 1'b1;
                        if (burst_len == '0) begin
                            state_reg <= DONE;
                            done      <= 1'b1;
                        end else begin
                            sram_B_addr    <= base_addr;
                            issue_left_reg <= burst_len - (ADDR_W+1)'(1);
                            state_reg      <= (burst_len == (ADDR_W+1)'(1)) ? DRAIN : ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (credit) begin
                        sram_B_addr    <= sram_B_addr + ADDR_W'(1);
                        issue_left_reg <= issue_left_reg - (ADDR_W+1)'(1);
                        if (issue_left_reg == (ADDR_W+1)'(1)) begin
                            state_reg <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        state_reg <= DONE;
                        done      <= 1'b1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Shift the read-valid tag alongside the SRAM read latency.
    always_ff @(posedge rpll_clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_reg <= '0;
        end else begin
            tag_reg <= {tag_reg[READ_LAT-1:0], issue_now};
        end
    end

    // FIFO storage: capture SRAM data when its tag reaches the last stage.
    always_ff @(posedge rpll_clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= sram_B_dout;
        end
    end

    // FIFO pointers and occupancy; push and pop together leave count unchanged.
    always_ff @(posedge rpll_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= (wr_ptr_reg == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= (rd_ptr_reg == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_next;
        end
    end

    // Beat index of the byte currently at the FIFO head, for m_last.
    always_ff @(posedge rpll_clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_reg <= '0;
        end else if (accept) begin
            beat_reg <= '0;
        end else if (pop) begin
            beat_reg <= beat_reg + (ADDR_W+1)'(1);
        end
    end

`ifdef SRAM_B_RD_CHECKSUM_EN
    logic [15:0] checksum_reg;

    // Wrapping sum of handshaked bytes; cleared on accept, held after done.
    always_ff @(posedge rpll_clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum_reg <= '0;
        end else if (accept) begin
            checksum_reg <= '0;
        end else if (pop) begin
            checksum_reg <= checksum_reg + 16'(m_data);
        end
    end

    assign checksum = checksum_reg;
`else
    assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_sram_b_burst_reader.sv
// Testbench for sram_b_burst_reader: two instances (READ_LAT=1 and 2) share
// stimulus; each has its own SRAM model and a per-cycle checker against a
// queue of expected bytes computed from base + index mod 1024.
module tb_sram_b_burst_reader;

    logic        rpll_clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [9:0]  base_addr;
    logic [10:0] burst_len;
    logic        m_ready;
    logic        accept_flag;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0]  exp_mem  [2][1024];
    int          exp_wr   [2];
    int          exp_rd   [2];
    logic [7:0]  got_mem  [2][1024];
    int          got_n    [2];
    int          done_cnt [2];
    int          done_cyc [2];
    logic [15:0] model_sum[2];
    logic [15:0] cs_view  [2];

    logic [7:0] lit_wrap [8];
    logic [7:0] lit_fresh[4];

    always #5 rpll_clk = ~rpll_clk;

    task automatic chk(input string nm, input int inst, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s inst%0d: got 0x%0h, required 0x%0h", nm, inst, act, req);
        end
    endtask

    function automatic logic [7:0] model_byte(input logic [9:0] b, input int k);
        logic [9:0] a;
        a = b + 10'(k);
        return a[7:0];
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        localparam int RL = gi + 1;
        logic        busy, done, sram_we, m_valid, m_last;
        logic [9:0]  sram_addr;
        logic [7:0]  sram_din, sram_dout, m_data;
        logic [15:0] checksum;
        logic [7:0]  mem [1024];
        logic [7:0]  rd_pipe [RL];

        int         cyc = 0;
        bit         seen_first = 1'b1;
        bit         armed = 1'b0;
        bit         stall_prev = 1'b0;
        bit         prev_done = 1'b0;
        logic [7:0] prev_data;
        logic       prev_last;

        sram_b_burst_reader #(
            .ADDR_W(10), .DATA_W(8), .READ_LAT(RL), .FIFO_DEPTH(4)
        ) u_dut (
            .rpll_clk(rpll_clk), .rst_n(rst_n), .start(start),
            .base_addr(base_addr), .burst_len(burst_len),
            .busy(busy), .done(done),
            .sram_B_addr(sram_addr), .sram_B_we(sram_we), .sram_B_din(sram_din),
            .sram_B_dout(sram_dout),
            .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
            .checksum(checksum)
        );

        initial begin
            for (int a = 0; a < 1024; a++) mem[a] = a[7:0];
        end

        always @(posedge rpll_clk) begin
            rd_pipe[0] <= mem[sram_addr];
            for (int k = 1; k < RL; k++) rd_pipe[k] <= rd_pipe[k-1];
        end
        assign sram_dout   = rd_pipe[RL-1];
        assign cs_view[gi] = checksum;

        always @(negedge rpll_clk) begin
            if (!rst_n) begin
                chk("reset_ctrl", gi, {busy, done, m_valid, m_last, sram_we}, 64'd0);
                chk("reset_data", gi, {m_data, sram_addr, checksum, sram_din}, 64'd0);
                exp_rd[gi]    = exp_wr[gi];
                model_sum[gi] = '0;
                stall_prev    = 1'b0;
                prev_done     = 1'b0;
                armed         = 1'b0;
            end else begin
                cyc++;
                chk("write_tied_off", gi, {sram_we, sram_din}, 64'd0);
`ifdef SRAM_B_RD_CHECKSUM_EN
                chk("checksum", gi, checksum, model_sum[gi]);
`else
                chk("checksum", gi, checksum, 64'd0);
`endif
                if (armed && cyc == 1) begin
                    chk("busy_after_start", gi, busy, 64'd1);
                    armed = 1'b0;
                end
                if (stall_prev)
                    chk("stall_hold", gi, {m_valid, m_last, m_data}, {1'b1, prev_last, prev_data});
                if (prev_done)
                    chk("done_one_cycle", gi, {done, busy}, 64'd0);
                if (exp_rd[gi] == exp_wr[gi]) begin
                    chk("no_beat_expected", gi, m_valid, 64'd0);
                end else if (m_valid) begin
                    if (!seen_first) begin
                        chk("first_beat_latency", gi, cyc, RL + 2);
                        seen_first = 1'b1;
                    end
                    chk("m_data", gi, m_data, exp_mem[gi][exp_rd[gi]]);
                    chk("m_last", gi, m_last, (exp_wr[gi] - exp_rd[gi]) == 1);
                    if (m_ready) begin
                        got_mem[gi][got_n[gi]] = m_data;
                        got_n[gi]++;
                        model_sum[gi] = model_sum[gi] + 16'(m_data);
                        exp_rd[gi]++;
                    end
                end else begin
                    chk("last_without_valid", gi, m_last, 64'd0);
                end
                if (done) begin
                    done_cnt[gi]++;
                    done_cyc[gi] = cyc;
                    chk("done_after_all_beats", gi, exp_wr[gi] - exp_rd[gi], 64'd0);
                    chk("busy_with_done", gi, busy, 64'd1);
                end
                stall_prev = m_valid && !m_ready;
                prev_data  = m_data;
                prev_last  = m_last;
                prev_done  = done;
                if (start && accept_flag) begin
                    cyc           = 0;
                    seen_first    = 1'b0;
                    armed         = 1'b1;
                    model_sum[gi] = '0;
                end
            end
        end
    end

    task automatic step();
        @(posedge rpll_clk);
        #1;
    endtask

    task automatic drive_ready(input int mode);
        if (mode == 0) m_ready = 1'b1;
        else           m_ready = ($urandom_range(0, 99) < 30);
    endtask

    task automatic launch(input logic [9:0] b, input logic [10:0] n, input int mode);
        for (int i = 0; i < 2; i++) begin
            exp_rd[i]   = 0;
            got_n[i]    = 0;
            done_cnt[i] = 0;
            for (int k = 0; k < int'(n); k++) exp_mem[i][k] = model_byte(b, k);
            exp_wr[i] = int'(n);
        end
        start       = 1'b1;
        base_addr   = b;
        burst_len   = n;
        accept_flag = 1'b1;
        drive_ready(mode);
        step();
        start       = 1'b0;
        accept_flag = 1'b0;
    endtask

    task automatic wait_done(input int mode, input int len);
        int waited;
        waited = 0;
        while (!(done_cnt[0] > 0 && done_cnt[1] > 0) && waited < 3000) begin
            drive_ready(mode);
            step();
            waited++;
        end
        if (waited >= 3000) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: got no done after %0d cycles, required done", waited);
        end
        m_ready = 1'b1;
        step();
        step();
        for (int i = 0; i < 2; i++) begin
            chk("done_pulses", i, done_cnt[i], 64'd1);
            chk("beat_count", i, got_n[i], len);
            if (mode == 0)
                chk("done_cycle", i, done_cyc[i], (len == 0) ? 1 : (i + len + 3));
        end
    endtask

    task automatic burst(input logic [9:0] b, input logic [10:0] n, input int mode);
        launch(b, n, mode);
        wait_done(mode, int'(n));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        lit_wrap  = '{8'hFC, 8'hFD, 8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h03};
        lit_fresh = '{8'h64, 8'h65, 8'h66, 8'h67};
        rst_n = 1'b0; start = 1'b0; base_addr = '0; burst_len = '0;
        m_ready = 1'b0; accept_flag = 1'b0;
        for (int i = 0; i < 2; i++) begin
            exp_wr[i] = 0; exp_rd[i] = 0; got_n[i] = 0;
            done_cnt[i] = 0; done_cyc[i] = 0; model_sum[i] = '0;
        end
        repeat (3) @(posedge rpll_clk);
        #1 rst_n = 1'b1;
        step();

        // 1: base 0, len 16, ready high
        burst(10'd0, 11'd16, 0);
        for (int i = 0; i < 2; i++) begin
            chk("t1_first_byte", i, got_mem[i][0], 8'h00);
            chk("t1_last_byte", i, got_mem[i][15], 8'h0F);
        end

        // 2: address wrap
        burst(10'd1020, 11'd8, 0);
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 8; k++) chk("t2_wrap_byte", i, got_mem[i][k], lit_wrap[k]);

        // 3: random 30% ready
        burst(10'd500, 11'd64, 1);

        // 4a: zero-length burst
        burst(10'd33, 11'd0, 0);

        // 4b: start mid-burst is ignored
        launch(10'd300, 11'd10, 0);
        step(); step(); step();
        start = 1'b1; base_addr = 10'd7; burst_len = 11'd5;
        step();
        start = 1'b0;
        wait_done(0, 10);

        // 5: reset mid-burst, then a fresh burst
        launch(10'd200, 11'd20, 0);
        repeat (7) step();
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 2; i++) chk("no_done_on_abort", i, done_cnt[i], 64'd0);
        burst(10'd100, 11'd4, 0);
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 4; k++) chk("t5_fresh_byte", i, got_mem[i][k], lit_fresh[k]);

        // 6: full 256-byte checksum
        burst(10'd0, 11'd256, 0);
        for (int i = 0; i < 2; i++) begin
`ifdef SRAM_B_RD_CHECKSUM_EN
            chk("t6_checksum", i, cs_view[i], 16'h7F80);
`else
            chk("t6_checksum", i, cs_view[i], 16'h0000);
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
